// File: rtl/rng_pkg.sv
// rng_pkg: shared types, default tap masks and seed for the LFSR random stream
package rng_pkg;
   typedef enum logic {EMPTY, FULL} rng_state_e;
   localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
   localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
   localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
   localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;
   localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;
   // maximal-length mask for the common widths, 16-bit mask otherwise
   function automatic logic [31:0] default_taps(int w);
      return w == 8 ? 32'(LFSR_TAPS_8) : w == 24 ? 32'(LFSR_TAPS_24) :
             w == 32 ? LFSR_TAPS_32 : 32'(LFSR_TAPS_16);
   endfunction
endpackage

// File: rtl/lfsr_rng_stream_if.sv
// lfsr_rng_stream_if: control, seeding and valid/ready output stream of the LFSR generator
interface lfsr_rng_stream_if #(
   parameter int WIDTH = 16,
   parameter int OUT_W = 16
);
   logic             en;
   logic             seed_load;
   logic [WIDTH-1:0] seed_val;
   logic             rand_valid;
   logic             rand_ready;
   logic [OUT_W-1:0] rand_data;
   logic             seed_err;
   logic [31:0]      word_cnt;
   modport master (
      input  en, seed_load, seed_val, rand_ready,
      output rand_valid, rand_data, seed_err, word_cnt
   );
   modport slave (
      output en, seed_load, seed_val, rand_ready,
      input  rand_valid, rand_data, seed_err, word_cnt
   );
endinterface

// File: rtl/lfsr_step_n.sv
// lfsr_step_n: STEPS Fibonacci LFSR shifts unrolled combinationally
module lfsr_step_n
   import rng_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
   parameter int               STEPS = 16
) (
   input  logic [WIDTH-1:0] i_state,
   output logic [WIDTH-1:0] o_state
);
   logic [WIDTH-1:0] w_s [STEPS+1];
   assign w_s[0] = i_state;
   for (genvar g = 0; g < STEPS; g++) begin : g_step
      assign w_s[g+1] = {w_s[g][WIDTH-2:0], ^(w_s[g] & TAPS)};
   end
   assign o_state = w_s[STEPS];
endmodule

// File: rtl/lfsr_rng_stream.sv
// lfsr_rng_stream: parametrised LFSR word generator with reseed, lockup guard
// and a one-deep valid/ready output stage sustaining one word per cycle.
module lfsr_rng_stream
   import rng_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
   parameter int               STEPS = 16,
   parameter int               OUT_W = 16,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
   input logic               clk,
   input logic               rst,
   lfsr_rng_stream_if.master bus
);
   if (WIDTH < 4) begin : g_bad_width
      $error("lfsr_rng_stream: WIDTH must be >= 4");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_rng_stream: SEED must be nonzero");
   end
   if (!TAPS[WIDTH-1]) begin : g_bad_taps
      $error("lfsr_rng_stream: TAPS must include bit WIDTH-1");
   end
   if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
      $error("lfsr_rng_stream: STEPS out of range 1..WIDTH");
   end
   if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
      $error("lfsr_rng_stream: OUT_W out of range 1..WIDTH");
   end
   rng_state_e       r_st;
   logic [WIDTH-1:0] r_state;
   logic [OUT_W-1:0] r_data;
   logic             r_err;
   logic [31:0]      r_cnt;
   logic [WIDTH-1:0] w_src;
   logic [WIDTH-1:0] w_next;
   logic             w_adv;
   logic             w_zero_seed;
   // an all-zero state would lock the LFSR, so restart from SEED instead
   assign w_src       = (r_state == '0) ? SEED : r_state;
   assign w_adv       = bus.en && (r_st == EMPTY || bus.rand_ready);
   assign w_zero_seed = bus.seed_load && (bus.seed_val == '0);
   lfsr_step_n #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .STEPS (STEPS)
   ) u_step (
      .i_state (w_src),
      .o_state (w_next)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_st    <= EMPTY;
         r_state <= SEED;
         r_data  <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_err <= w_zero_seed;
         if (r_st == FULL && bus.rand_ready && !bus.seed_load) r_cnt <= r_cnt + 32'd1;
         if (bus.seed_load) begin
            r_state <= w_zero_seed ? SEED : bus.seed_val;
            r_st    <= EMPTY;
         end else if (w_adv) begin
            r_state <= w_next;
            r_data  <= w_next[OUT_W-1:0];
            r_st    <= FULL;
         end else if (r_st == FULL && bus.rand_ready) begin
            r_st <= EMPTY;
         end
      end
   assign bus.rand_valid = (r_st == FULL);
   assign bus.rand_data  = r_data;
   assign bus.seed_err   = r_err;
   assign bus.word_cnt   = r_cnt;
endmodule

// File: tb/tb_lfsr_rng_stream.sv
// tb_lfsr_rng_stream: scoreboard bench, STEPS=1 so every word is a single taps-16/14/13/11 shift
module tb_lfsr_rng_stream;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_tests = 0;
   int n_fail = 0;
   int n_hs = 0;
   logic [15:0] q[$];
   logic [15:0] m_state;
   logic [15:0] last_word = '0;
   always #5 clk = ~clk;
   lfsr_rng_stream_if #(.WIDTH(16), .OUT_W(16)) bus ();
   lfsr_rng_stream #(
      .WIDTH (16),
      .TAPS  (16'hB400),
      .STEPS (1),
      .OUT_W (16),
      .SEED  (16'hFFFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   function automatic logic [15:0] next16(logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic push_n(int n);
      for (int i = 0; i < n; i++) begin
         m_state = next16(m_state);
         q.push_back(m_state);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_empty(int lim);
      int c = 0;
      while (q.size() != 0 && c < lim) begin
         cyc();
         c++;
      end
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d words still expected after %0d cycles", q.size(), lim);
         q.delete();
      end
      bus.rand_ready = 1'b0;
   endtask
   // monitor: a word is consumed when valid&ready meet at an edge without a reseed
   initial forever begin
      @(negedge clk);
      if (!rst && bus.rand_valid && bus.rand_ready && !bus.seed_load) begin
         n_hs++;
         last_word = bus.rand_data;
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %h with no word expected", bus.rand_data);
         end else check("stream", {16'h0, bus.rand_data}, {16'h0, q.pop_front()});
      end
   end
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [15:0] hand [12] = '{16'hFFFE, 16'hFFFC, 16'hFFF8, 16'hFFF0, 16'hFFE0, 16'hFFC0,
                                 16'hFF80, 16'hFF00, 16'hFE00, 16'hFC00, 16'hF800, 16'hF001};
      int cnt0;
      int c;
      bus.en = 1'b0;
      bus.seed_load = 1'b0;
      bus.seed_val = '0;
      bus.rand_ready = 1'b0;
      cyc();
      check("rst_valid", {31'h0, bus.rand_valid}, 0);
      check("rst_data", {16'h0, bus.rand_data}, 0);
      check("rst_cnt", bus.word_cnt, 0);
      check("rst_err", {31'h0, bus.seed_err}, 0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) q.push_back(hand[i]);
      m_state = 16'hF001;
      bus.en = 1'b1;
      bus.rand_ready = 1'b1;
      cyc();
      wait_empty(50);
      check("cnt_after_12", bus.word_cnt, 12);
      check("valid_holding", {31'h0, bus.rand_valid}, 1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("stall_data", {16'h0, bus.rand_data}, 32'hE003);
         check("stall_cnt", bus.word_cnt, 12);
      end
      q.push_back(16'hE003);
      q.push_back(16'hC006);
      m_state = 16'hC006;
      push_n(20);
      bus.rand_ready = 1'b1;
      wait_empty(60);
      push_n(300);
      c = 0;
      while (q.size() != 0 && c < 3000) begin
         bus.en = ($urandom_range(0, 3) != 0);
         bus.rand_ready = $urandom_range(0, 1) != 0;
         cyc();
         c++;
      end
      wait_empty(1);
      check("cnt_random", bus.word_cnt, n_hs);
      bus.en = 1'b1;
      cyc();
      check("full_before_seed", {31'h0, bus.rand_valid}, 1);
      cnt0 = n_hs;
      bus.seed_load = 1'b1;
      bus.seed_val = 16'h0001;
      bus.rand_ready = 1'b1;
      cyc();
      bus.seed_load = 1'b0;
      bus.rand_ready = 1'b0;
      bus.en = 1'b0;
      check("seed_drop_valid", {31'h0, bus.rand_valid}, 0);
      check("seed_drop_cnt", bus.word_cnt, cnt0);
      check("seed_ok_err", {31'h0, bus.seed_err}, 0);
      q.push_back(16'h0002);
      q.push_back(16'h0004);
      q.push_back(16'h0008);
      m_state = 16'h0008;
      bus.en = 1'b1;
      cyc();
      check("latency_valid", {31'h0, bus.rand_valid}, 1);
      check("reseed_first", {16'h0, bus.rand_data}, 32'h0002);
      bus.rand_ready = 1'b1;
      wait_empty(20);
      bus.en = 1'b0;
      bus.seed_load = 1'b1;
      bus.seed_val = 16'h0000;
      cyc();
      bus.seed_load = 1'b0;
      check("zero_seed_err", {31'h0, bus.seed_err}, 1);
      cyc();
      check("zero_seed_err_end", {31'h0, bus.seed_err}, 0);
      check("zero_seed_valid", {31'h0, bus.rand_valid}, 0);
      q.push_back(16'hFFFE);
      q.push_back(16'hFFFC);
      q.push_back(16'hFFF8);
      m_state = 16'hFFF8;
      bus.en = 1'b1;
      bus.rand_ready = 1'b1;
      wait_empty(20);
      check("pre_rst_valid", {31'h0, bus.rand_valid}, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", {31'h0, bus.rand_valid}, 0);
      check("arst_data", {16'h0, bus.rand_data}, 0);
      check("arst_cnt", bus.word_cnt, 0);
      check("arst_err", {31'h0, bus.seed_err}, 0);
      n_hs = 0;
      cyc();
      rst = 1'b0;
      m_state = 16'hFFFF;
      push_n(65535);
      bus.rand_ready = 1'b1;
      wait_empty(70000);
      check("period_wrap", {16'h0, last_word}, 32'hFFFF);
      check("period_cnt", bus.word_cnt, n_hs);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
